// File: rtl/byte_frame_tx.sv
// Byte-stream frame transmitter: payload bytes are buffered in a FIFO, then sent as
// preamble, SFD, payload and an 8-bit additive checksum, followed by an inter-frame gap.
module byte_frame_tx #(
  parameter int         FIFO_DEPTH    = 16,
  parameter int         PREAMBLE_LEN  = 2,
  parameter int         IFG_LEN       = 3,
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0] SFD_BYTE      = 8'hD5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_cnt,
  output logic [2:0]  dbg_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int PCW = $clog2(PREAMBLE_LEN + 1);
  localparam int ICW = $clog2(IFG_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SFD   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_ABORT = 3'd5,
    S_IFG   = 3'd6
  } state_t;

  // Upstream handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_valid may rise freely, in_ready depends only on registered FIFO state.
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, held;
  logic          rdy_q;
  logic          fifo_full, fifo_empty, push, pop, frame_ready;
  logic [8:0]    head;

  state_t         state, state_n;
  logic [PCW-1:0] pre_cnt, pre_cnt_n;
  logic [ICW-1:0] ifg_cnt, ifg_cnt_n;
  logic [7:0]     csum, csum_n, txd_n;
  logic           cur_last, last_n, tx_en_n;
  logic           launch, frame_done, underrun_set;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready    = rdy_q && !fifo_full;
  assign push        = in_valid && in_ready;
  assign head        = mem[rd_ptr[AW-1:0]];
  // A full FIFO with no complete frame means the frame is longer than the buffer: cut through.
  assign frame_ready = (held != '0) || fifo_full;
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      held   <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push && in_last, pop && head[8]})
        2'b10:   held <= held + PW'(1);
        2'b01:   held <= held - PW'(1);
        default: ;
      endcase
    end
  end

  // Each branch computes the byte that goes on the line in the following cycle.
  always_comb begin
    state_n      = state;
    pre_cnt_n    = pre_cnt;
    ifg_cnt_n    = ifg_cnt;
    csum_n       = csum;
    last_n       = cur_last;
    txd_n        = 8'h00;
    tx_en_n      = 1'b0;
    pop          = 1'b0;
    launch       = 1'b0;
    frame_done   = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      S_IDLE: launch = frame_ready;
      S_PRE: begin
        tx_en_n = 1'b1;
        if (pre_cnt == PCW'(PREAMBLE_LEN)) begin
          state_n = S_SFD;
          txd_n   = SFD_BYTE;
        end else begin
          txd_n     = PREAMBLE_BYTE;
          pre_cnt_n = pre_cnt + PCW'(1);
        end
      end
      S_SFD, S_DATA: begin
        if (state == S_DATA && cur_last) begin
          state_n    = S_CSUM;
          tx_en_n    = 1'b1;
          txd_n      = csum;
          frame_done = 1'b1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          tx_en_n = 1'b1;
          txd_n   = head[7:0];
          csum_n  = csum + head[7:0];
          last_n  = head[8];
          state_n = S_DATA;
        end else begin
          underrun_set = 1'b1;
          state_n      = S_ABORT;
        end
      end
      S_CSUM: begin
        state_n   = S_IFG;
        ifg_cnt_n = ICW'(1);
      end
      S_ABORT: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[8]) begin
            state_n   = S_IFG;
            ifg_cnt_n = ICW'(1);
          end
        end
      end
      S_IFG: begin
        if (ifg_cnt == ICW'(IFG_LEN)) begin
          if (frame_ready) launch  = 1'b1;
          else             state_n = S_IDLE;
        end else begin
          ifg_cnt_n = ifg_cnt + ICW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Starting a frame emits the first preamble byte immediately.
    if (launch) begin
      state_n   = S_PRE;
      tx_en_n   = 1'b1;
      txd_n     = PREAMBLE_BYTE;
      pre_cnt_n = PCW'(1);
      csum_n    = 8'h00;
      last_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      ifg_cnt   <= '0;
      csum      <= 8'h00;
      cur_last  <= 1'b0;
      txd       <= 8'h00;
      tx_en     <= 1'b0;
      underrun  <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      state    <= state_n;
      pre_cnt  <= pre_cnt_n;
      ifg_cnt  <= ifg_cnt_n;
      csum     <= csum_n;
      cur_last <= last_n;
      txd      <= txd_n;
      tx_en    <= tx_en_n;
      if (underrun_set) underrun  <= 1'b1;
      if (frame_done)   frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_byte_frame_tx.sv
// Bench for byte_frame_tx: a line-schedule model predicts every output each cycle,
// and directed scenarios pin the captured byte streams to hand-computed literals.
module tb_byte_frame_tx;

  localparam int DEPTH = 16;
  localparam int PLEN  = 2;
  localparam int IFG   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  txd;
  logic        tx_en, busy, underrun;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_frame_tx #(
    .FIFO_DEPTH(DEPTH), .PREAMBLE_LEN(PLEN), .IFG_LEN(IFG),
    .PREAMBLE_BYTE(8'h55), .SFD_BYTE(8'hD5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .txd(txd), .tx_en(tx_en), .busy(busy), .underrun(underrun),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // Model: accepted bytes, a queue of fixed line entries {frame_done, en, byte}, and a mode.
  typedef enum {M_IDLE, M_PAY, M_DROP} mode_e;
  logic [8:0]  mfifo[$];
  logic [9:0]  sched[$];
  mode_e       mode = M_IDLE;
  logic [7:0]  m_csum = 8'h00;
  logic        exp_en = 1'b0, exp_busy = 1'b0, exp_und = 1'b0, rdy_ok = 1'b0;
  logic [7:0]  exp_txd = 8'h00;
  logic [15:0] exp_fc = 16'h0000;

  logic [7:0]  cap_q[$];
  int          gap_q[$];
  int          idle_run = 0;
  bit          seen_tx = 1'b0;
  int          nr_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_has_last();
    foreach (mfifo[i]) if (mfifo[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [9:0] e;
    logic [8:0] h;
    exp_busy = 1'b1;
    exp_en   = 1'b0;
    exp_txd  = 8'h00;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      exp_en  = e[8];
      exp_txd = e[7:0];
      if (e[9]) exp_fc = exp_fc + 16'd1;
    end else begin
      case (mode)
        M_PAY: begin
          if (mfifo.size() > 0) begin
            h = mfifo.pop_front();
            exp_en  = 1'b1;
            exp_txd = h[7:0];
            m_csum  = m_csum + h[7:0];
            if (h[8]) begin
              sched.push_back({2'b11, m_csum});
              for (int i = 0; i < IFG; i++) sched.push_back(10'h000);
              mode = M_IDLE;
            end
          end else begin
            exp_und = 1'b1;
            mode    = M_DROP;
          end
        end
        M_DROP: begin
          if (mfifo.size() > 0) begin
            h = mfifo.pop_front();
            if (h[8]) begin
              for (int i = 0; i < IFG - 1; i++) sched.push_back(10'h000);
              mode = M_IDLE;
            end
          end
        end
        default: begin
          if (m_has_last() || mfifo.size() == DEPTH) begin
            exp_en  = 1'b1;
            exp_txd = 8'h55;
            for (int i = 0; i < PLEN - 1; i++) sched.push_back({2'b01, 8'h55});
            sched.push_back({2'b01, 8'hD5});
            m_csum = 8'h00;
            mode   = M_PAY;
          end else begin
            exp_busy = 1'b0;
          end
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mfifo.delete();
      sched.delete();
      mode = M_IDLE; m_csum = 8'h00;
      exp_en = 1'b0; exp_txd = 8'h00; exp_busy = 1'b0; exp_und = 1'b0;
      exp_fc = 16'h0000; rdy_ok = 1'b0;
      seen_tx = 1'b0; idle_run = 0;
      check("rst_tx_en", 32'(tx_en), 32'(0));
      check("rst_txd", 32'(txd), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_underrun", 32'(underrun), 32'(0));
      check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
    end else begin
      check("tx_en", 32'(tx_en), 32'(exp_en));
      check("txd", 32'(txd), 32'(exp_txd));
      check("busy", 32'(busy), 32'(exp_busy));
      check("underrun", 32'(underrun), 32'(exp_und));
      check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      check("in_ready", 32'(in_ready), 32'(rdy_ok && (mfifo.size() < DEPTH)));
      if (tx_en) begin
        if (seen_tx && idle_run > 0) gap_q.push_back(idle_run);
        idle_run = 0;
        seen_tx  = 1'b1;
        cap_q.push_back(txd);
      end else begin
        idle_run++;
      end
      if (!in_ready) nr_cycles++;
      model_step();
      if (in_valid && in_ready) mfifo.push_back({in_last, in_data});
      rdy_ok = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    check("accept_wait", 32'(n < 500), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_quiet();
    int n = 0;
    @(negedge clk); #1;
    while (!(mode == M_IDLE && sched.size() == 0 && mfifo.size() == 0) && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    check("quiet_timeout", 32'(n >= 600), 32'(0));
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_cap(input string name, input logic [7:0] exp_b[$]);
    check({name, "_len"}, 32'(cap_q.size()), 32'(exp_b.size()));
    foreach (exp_b[i])
      if (i < cap_q.size()) check($sformatf("%s[%0d]", name, i), 32'(cap_q[i]), 32'(exp_b[i]));
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] exp_b[$];
    int n, g0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    check("ready_after_edge", 32'(in_ready), 32'(1));

    // Basic three-byte frame
    cap_q.delete();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h06};
    check_cap("basic", exp_b);
    check("basic_frame_cnt", 32'(frame_cnt), 32'(1));
    check("basic_ifg_min", 32'(idle_run >= 3), 32'(1));

    // Checksum wraps modulo 256
    cap_q.delete();
    send_byte(8'hFF, 1'b0); send_byte(8'h02, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5, 8'hFF, 8'h02, 8'h01};
    check_cap("wrap", exp_b);

    // Two single-byte frames back to back
    cap_q.delete();
    g0 = gap_q.size();
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'hD5, 8'hBB, 8'hBB};
    check_cap("b2b", exp_b);
    check("b2b_gap_count", 32'(gap_q.size() - g0), 32'(2));
    if (gap_q.size() > 0) check("b2b_gap_len", 32'(gap_q[$]), 32'(3));
    check("b2b_frame_cnt", 32'(frame_cnt), 32'(4));

    // 20-byte frame at full rate: cut-through on full FIFO
    cap_q.delete();
    nr_cycles = 0;
    for (int i = 1; i <= 20; i++) send_byte(8'(i), i == 20);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5};
    for (int i = 1; i <= 20; i++) exp_b.push_back(8'(i));
    exp_b.push_back(8'hD2);
    check_cap("long", exp_b);
    check("long_ready_dropped", 32'(nr_cycles > 0), 32'(1));
    check("long_underrun", 32'(underrun), 32'(0));
    check("long_frame_cnt", 32'(frame_cnt), 32'(5));

    // Cut-through frame starved mid-payload: abort, then a normal frame
    cap_q.delete();
    for (int i = 1; i <= 14; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
    idle_cycles(30);
    send_byte(8'h30, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5};
    for (int i = 1; i <= 14; i++) exp_b.push_back(8'(i));
    exp_b.push_back(8'h10); exp_b.push_back(8'h20);
    check_cap("abort", exp_b);
    check("abort_underrun", 32'(underrun), 32'(1));
    check("abort_frame_cnt", 32'(frame_cnt), 32'(5));
    cap_q.delete();
    send_byte(8'h42, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5, 8'h42, 8'h42};
    check_cap("after_abort", exp_b);
    check("after_abort_frame_cnt", 32'(frame_cnt), 32'(6));

    // Asynchronous reset in the middle of a payload
    cap_q.delete();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    n = 0;
    while (cap_q.size() < 5 && n < 100) begin @(negedge clk); #1; n++; end
    check("midreset_reach_data", 32'(n < 100), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx_en", 32'(tx_en), 32'(0));
    check("midreset_txd", 32'(txd), 32'(0));
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_underrun", 32'(underrun), 32'(0));
    check("midreset_frame_cnt", 32'(frame_cnt), 32'(0));
    check("midreset_in_ready", 32'(in_ready), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cap_q.delete();
    send_byte(8'h7F, 1'b1);
    wait_quiet();
    exp_b = '{8'h55, 8'h55, 8'hD5, 8'h7F, 8'h7F};
    check_cap("post_reset", exp_b);
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'(1));

    // Random frames with random upstream stalls
    for (int f = 0; f < 14; f++) begin
      int len, gmax;
      len  = $urandom_range(1, 24);
      gmax = ($urandom_range(0, 2) == 0) ? 3 : 0;
      for (int b = 0; b < len; b++) begin
        send_byte(8'($urandom_range(0, 255)), b == len - 1);
        if (gmax > 0) idle_cycles($urandom_range(0, gmax));
      end
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 6));
    end
    wait_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
